// File: rtl/message_slicer_fifo.sv
// message_slicer_fifo: splits multi-slice input words into a WIDTH-bit output stream through a circular buffer.
// Optional MESSAGE_SLICER_FIFO_LAST_EN adds out_last marking the final slice of each input word.
module message_slicer_fifo #(
  parameter int N_SLICES          = 2,
  parameter int LOG_N_SLICES      = 1,
  parameter int WIDTH             = 32,
  parameter int BUFFER_LENGTH     = 64,
  parameter int LOG_BUFFER_LENGTH = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WIDTH*N_SLICES-1:0]     in_data,
  input  logic [LOG_N_SLICES:0]         in_count,
  input  logic                          in_nd,
  output logic                          in_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_nd,
  input  logic                          out_ready,
  output logic [LOG_BUFFER_LENGTH:0]    fill,
`ifdef MESSAGE_SLICER_FIFO_LAST_EN
  output logic                          out_last,
`endif
  output logic                          error
);
  localparam int FW = LOG_BUFFER_LENGTH + 1;
  localparam int CW = LOG_N_SLICES + 1;
  logic [WIDTH-1:0] mem [BUFFER_LENGTH];
`ifdef MESSAGE_SLICER_FIFO_LAST_EN
  logic last_mem [BUFFER_LENGTH];
`endif
  logic [LOG_BUFFER_LENGTH-1:0] wr_ptr, rd_ptr;
  logic [FW-1:0] free, cnt;
  logic wr_ok, bad_word, load;
  assign cnt      = FW'(in_count);
  assign free     = FW'(BUFFER_LENGTH) - fill;
  assign in_ready = free >= FW'(N_SLICES);
  assign wr_ok    = in_nd && in_count != '0 && in_count <= CW'(N_SLICES) && free >= cnt;
  assign bad_word = in_nd && in_count != '0 && !wr_ok;
  assign load     = fill != '0 && (!out_nd || out_ready);
  // Top slice lands first so the stream reads the word from the most significant end.
  always_ff @(posedge clk)
    if (wr_ok)
      for (int k = 0; k < N_SLICES; k++)
        if (CW'(k) < in_count) begin
          mem[wr_ptr + LOG_BUFFER_LENGTH'(k)] <= in_data[(N_SLICES-k)*WIDTH-1 -: WIDTH];
`ifdef MESSAGE_SLICER_FIFO_LAST_EN
          last_mem[wr_ptr + LOG_BUFFER_LENGTH'(k)] <= CW'(k + 1) == in_count;
`endif
        end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      out_data <= '0;
      out_nd   <= 1'b0;
      error    <= 1'b0;
`ifdef MESSAGE_SLICER_FIFO_LAST_EN
      out_last <= 1'b0;
`endif
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + cnt[LOG_BUFFER_LENGTH-1:0];
      if (load) rd_ptr <= rd_ptr + LOG_BUFFER_LENGTH'(1);
      fill  <= fill + (wr_ok ? cnt : '0) - FW'(load);
      error <= error | bad_word;
      if (load) begin
        out_data <= mem[rd_ptr];
        out_nd   <= 1'b1;
`ifdef MESSAGE_SLICER_FIFO_LAST_EN
        out_last <= last_mem[rd_ptr];
`endif
      end else if (out_ready) out_nd <= 1'b0;
    end
endmodule
